// File: rtl/tlp_action_exec.sv
// Executes RX->TX actions: register writes, register reads answered with a
// two-beat 3DW completion TLP, error recording, and discard of reserved actions.
module tlp_action_exec #(
  parameter int unsigned ERRCNT_WIDTH = 16
) (
  input  logic                    pcieClk_in,
  input  logic                    pcieRst_in,
  input  logic [15:0]             cfgBusDev_in,
  input  logic [42:0]             actData_in,
  input  logic                    actValid_in,
  output logic                    actReady_out,
  output logic                    regRdReq_out,
  output logic [8:0]              regRdChan_out,
  input  logic                    regRdAck_in,
  input  logic [31:0]             regRdData_in,
  output logic                    regWrValid_out,
  output logic [8:0]              regWrChan_out,
  output logic [31:0]             regWrData_out,
  output logic [63:0]             txData_out,
  output logic                    txValid_out,
  input  logic                    txReady_in,
  output logic                    txSOP_out,
  output logic                    txEOP_out,
  output logic [31:0]             errCode_out,
  output logic [ERRCNT_WIDTH-1:0] errCount_out
);

  localparam int unsigned CHAN_W = 9;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] ACT_READ  = 2'd0;
  localparam logic [1:0] ACT_WRITE = 2'd1;
  localparam logic [1:0] ACT_ERROR = 2'd2;

  // Completion header dword: fmt=3DW with data, type=completion, length 1
  localparam logic [31:0] CPL_DW0    = 32'h4A00_0001;
  localparam logic [11:0] BYTE_COUNT = 12'd4;

  typedef enum logic [1:0] {IDLE, RD_WAIT, SEND_QW0, SEND_QW1} state_t;

  state_t state, state_next;

  logic [1:0]        act_typ;
  logic [CHAN_W-1:0] act_chan;
  logic [DATA_W-1:0] act_payload;
  logic              accept;

  logic [15:0]       bus_dev_q;
  logic [15:0]       req_id_q;
  logic [7:0]        tag_q;
  logic [DATA_W-1:0] rd_data_q;

  assign act_typ     = actData_in[42:41];
  assign act_chan    = actData_in[40:32];
  assign act_payload = actData_in[31:0];
  assign actReady_out = (state == IDLE);
  assign accept       = actValid_in && (state == IDLE);

  // State register
  always_ff @(posedge pcieClk_in or posedge pcieRst_in) begin
    if (pcieRst_in) state <= IDLE;
    else            state <= state_next;
  end

  // Next-state: reads hold the pipe until both completion beats are handshaken
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (accept && (act_typ == ACT_READ)) state_next = RD_WAIT;
      RD_WAIT:  if (regRdAck_in) state_next = SEND_QW0;
      SEND_QW0: if (txValid_out && txReady_in) state_next = SEND_QW1;
      SEND_QW1: if (txValid_out && txReady_in) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Read request, transmit port and completion beat assembly
  always_ff @(posedge pcieClk_in or posedge pcieRst_in) begin
    if (pcieRst_in) begin
      regRdReq_out  <= 1'b0;
      regRdChan_out <= '0;
      bus_dev_q     <= '0;
      req_id_q      <= '0;
      tag_q         <= '0;
      rd_data_q     <= '0;
      txValid_out   <= 1'b0;
      txSOP_out     <= 1'b0;
      txEOP_out     <= 1'b0;
      txData_out    <= '0;
    end else begin
      regRdReq_out <= (state_next == RD_WAIT);
      txValid_out  <= (state_next == SEND_QW0) || (state_next == SEND_QW1);
      txSOP_out    <= (state_next == SEND_QW0);
      txEOP_out    <= (state_next == SEND_QW1);
      if (accept && (act_typ == ACT_READ)) begin
        regRdChan_out <= act_chan;
        bus_dev_q     <= cfgBusDev_in;
        req_id_q      <= act_payload[31:16];
        tag_q         <= act_payload[15:8];
      end
      if ((state == RD_WAIT) && regRdAck_in) begin
        rd_data_q  <= regRdData_in;
        txData_out <= {bus_dev_q, 3'b000, 1'b0, BYTE_COUNT, CPL_DW0};
      end
      if ((state == SEND_QW0) && (state_next == SEND_QW1)) begin
        txData_out <= {rd_data_q, req_id_q, tag_q,
                       1'b0, regRdChan_out[3:0], 1'b1, 2'b00};
      end
    end
  end

  // Register-write strobe: one cycle per accepted write
  always_ff @(posedge pcieClk_in or posedge pcieRst_in) begin
    if (pcieRst_in) begin
      regWrValid_out <= 1'b0;
      regWrChan_out  <= '0;
      regWrData_out  <= '0;
    end else begin
      regWrValid_out <= accept && (act_typ == ACT_WRITE);
      if (accept && (act_typ == ACT_WRITE)) begin
        regWrChan_out <= act_chan;
        regWrData_out <= act_payload;
      end
    end
  end

  // Error code capture and saturating error count
  always_ff @(posedge pcieClk_in or posedge pcieRst_in) begin
    if (pcieRst_in) begin
      errCode_out  <= '0;
      errCount_out <= '0;
    end else if (accept && (act_typ == ACT_ERROR)) begin
      errCode_out <= act_payload;
      if (!(&errCount_out)) errCount_out <= errCount_out + ERRCNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_tlp_action_exec.sv
// Bench for tlp_action_exec: vector table, directed read/reset sequences and
// randomized traffic against a transaction-level reference model.
module tb_tlp_action_exec;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cfg_bus_dev;
  logic [42:0] act_data;
  logic        act_valid, act_ready;
  logic        rd_req, rd_ack;
  logic [8:0]  rd_chan;
  logic [31:0] rd_data;
  logic        wr_valid;
  logic [8:0]  wr_chan;
  logic [31:0] wr_data;
  logic [63:0] tx_data;
  logic        tx_valid, tx_ready, tx_sop, tx_eop;
  logic [31:0] err_code;
  logic [15:0] err_count;

  logic        d2_act_ready, d2_rd_req, d2_wr_valid, d2_tx_valid, d2_tx_sop, d2_tx_eop;
  logic [8:0]  d2_rd_chan, d2_wr_chan;
  logic [31:0] d2_wr_data, d2_err_code;
  logic [63:0] d2_tx_data;
  logic [1:0]  d2_err_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tlp_action_exec #(.ERRCNT_WIDTH(16)) dut (
    .pcieClk_in(clk), .pcieRst_in(rst), .cfgBusDev_in(cfg_bus_dev),
    .actData_in(act_data), .actValid_in(act_valid), .actReady_out(act_ready),
    .regRdReq_out(rd_req), .regRdChan_out(rd_chan), .regRdAck_in(rd_ack),
    .regRdData_in(rd_data), .regWrValid_out(wr_valid), .regWrChan_out(wr_chan),
    .regWrData_out(wr_data), .txData_out(tx_data), .txValid_out(tx_valid),
    .txReady_in(tx_ready), .txSOP_out(tx_sop), .txEOP_out(tx_eop),
    .errCode_out(err_code), .errCount_out(err_count)
  );

  tlp_action_exec #(.ERRCNT_WIDTH(2)) dut2 (
    .pcieClk_in(clk), .pcieRst_in(rst), .cfgBusDev_in(cfg_bus_dev),
    .actData_in(act_data), .actValid_in(act_valid), .actReady_out(d2_act_ready),
    .regRdReq_out(d2_rd_req), .regRdChan_out(d2_rd_chan), .regRdAck_in(rd_ack),
    .regRdData_in(rd_data), .regWrValid_out(d2_wr_valid), .regWrChan_out(d2_wr_chan),
    .regWrData_out(d2_wr_data), .txData_out(d2_tx_data), .txValid_out(d2_tx_valid),
    .txReady_in(tx_ready), .txSOP_out(d2_tx_sop), .txEOP_out(d2_tx_eop),
    .errCode_out(d2_err_code), .errCount_out(d2_err_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Full read transaction with configurable ack delay and per-beat backpressure
  task automatic do_read(input string nm, input logic [15:0] bd, input logic [8:0] ch,
                         input logic [15:0] rid, input logic [7:0] tg, input logic [31:0] d,
                         input int ack_dly, input int bp0, input int bp1);
    logic [63:0] q0, q1;
    q0 = {bd, 16'h0004, 32'h4A00_0001};
    q1 = {d, rid, tg, 1'b0, ch[3:0], 1'b1, 2'b00};
    chk({nm, "_ready_pre"}, 64'(act_ready), 64'd1);
    cfg_bus_dev = bd;
    act_data    = {2'd0, ch, rid, tg, 8'h00};
    act_valid   = 1'b1;
    tx_ready    = 1'b0;
    tick();
    act_valid   = 1'b0;
    act_data    = '1;
    cfg_bus_dev = ~bd;
    chk({nm, "_req"}, 64'(rd_req), 64'd1);
    chk({nm, "_req_chan"}, 64'(rd_chan), 64'(ch));
    chk({nm, "_ready_busy"}, 64'(act_ready), 64'd0);
    for (int i = 0; i < ack_dly; i++) begin
      tick();
      chk({nm, "_req_hold"}, 64'(rd_req), 64'd1);
      chk({nm, "_txv_wait"}, 64'(tx_valid), 64'd0);
    end
    rd_ack  = 1'b1;
    rd_data = d;
    tick();
    rd_ack  = 1'b0;
    rd_data = 32'h0;
    chk({nm, "_req_drop"}, 64'(rd_req), 64'd0);
    chk({nm, "_qw0_v"}, 64'(tx_valid), 64'd1);
    chk({nm, "_qw0"}, tx_data, q0);
    chk({nm, "_qw0_sopeop"}, 64'({tx_sop, tx_eop}), 64'd2);
    for (int i = 0; i < bp0; i++) begin
      tx_ready = 1'b0;
      tick();
      chk({nm, "_qw0_hold"}, {tx_data}, q0);
      chk({nm, "_qw0_hold_ctl"}, 64'({tx_valid, tx_sop, tx_eop, act_ready}), 64'b1100);
    end
    tx_ready = 1'b1;
    tick();
    chk({nm, "_qw1"}, tx_data, q1);
    chk({nm, "_qw1_ctl"}, 64'({tx_valid, tx_sop, tx_eop, act_ready}), 64'b1010);
    for (int i = 0; i < bp1; i++) begin
      tx_ready = 1'b0;
      tick();
      chk({nm, "_qw1_hold"}, tx_data, q1);
      chk({nm, "_qw1_hold_ctl"}, 64'({tx_valid, tx_sop, tx_eop, act_ready}), 64'b1010);
    end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    chk({nm, "_done"}, 64'({tx_valid, act_ready}), 64'b01);
  endtask

  typedef struct {
    logic [1:0]  typ;
    logic [8:0]  chan;
    logic [31:0] pay;
    logic        wr_v;
    logic [31:0] code;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } vec_t;

  typedef struct packed {
    logic [63:0] d;
    logic        sop;
    logic        eop;
  } beat_t;

  vec_t        tbl[8];
  beat_t       beats_q[$];
  // reference model state
  logic        m_inflight, m_acked, m_wr_pend;
  logic [8:0]  m_wr_chan, m_rd_chan;
  logic [31:0] m_wr_data, m_code;
  logic [15:0] m_cnt, m_bd, m_rid;
  logic [7:0]  m_tag;
  int          m_cnt2;
  logic        prev_stall;
  logic [65:0] prev_tx;

  initial begin
    rst = 1'b1; cfg_bus_dev = '0; act_data = '0; act_valid = 1'b0;
    rd_ack = 1'b0; rd_data = '0; tx_ready = 1'b0;
    repeat (3) tick();
    chk("rst_outputs", 64'({rd_req, wr_valid, tx_valid, tx_sop, tx_eop}), 64'd0);
    chk("rst_txdata", tx_data, 64'd0);
    chk("rst_err", 64'({err_code, err_count}), 64'd0);
    rst = 1'b0;
    tick();
    chk("rst_ready", 64'(act_ready), 64'd1);

    // single-action vectors
    tbl[0] = '{2'd1, 9'h005, 32'hDEADBEEF, 1'b1, 32'd0, 16'd0, 2'd0};
    tbl[1] = '{2'd1, 9'h1FF, 32'h1234_5678, 1'b1, 32'd0, 16'd0, 2'd0};
    tbl[2] = '{2'd2, 9'h000, 32'd1,         1'b0, 32'd1, 16'd1, 2'd1};
    tbl[3] = '{2'd2, 9'h0AA, 32'd2,         1'b0, 32'd2, 16'd2, 2'd2};
    tbl[4] = '{2'd3, 9'h003, 32'hFFFF_FFFF, 1'b0, 32'd2, 16'd2, 2'd2};
    tbl[5] = '{2'd2, 9'h001, 32'd3,         1'b0, 32'd3, 16'd3, 2'd3};
    tbl[6] = '{2'd2, 9'h002, 32'd4,         1'b0, 32'd4, 16'd4, 2'd3};
    tbl[7] = '{2'd3, 9'h1F0, 32'h0BAD_F00D, 1'b0, 32'd4, 16'd4, 2'd3};
    for (int i = 0; i < 8; i++) begin
      act_data  = {tbl[i].typ, tbl[i].chan, tbl[i].pay};
      act_valid = 1'b1;
      tick();
      act_valid = 1'b0;
      chk("vec_wr_valid", 64'(wr_valid), 64'(tbl[i].wr_v));
      if (tbl[i].wr_v) chk("vec_wr_fields", {23'd0, wr_chan, wr_data}, {23'd0, tbl[i].chan, tbl[i].pay});
      chk("vec_err_code", 64'(err_code), 64'(tbl[i].code));
      chk("vec_err_count", 64'(err_count), 64'(tbl[i].cnt));
      chk("vec_err_count_w2", 64'(d2_err_count), 64'(tbl[i].cnt2));
      chk("vec_idle", 64'({act_ready, rd_req, tx_valid}), 64'b100);
      tick();
      chk("vec_wr_oneshot", 64'(wr_valid), 64'd0);
    end

    // back-to-back writes
    for (int i = 0; i < 3; i++) begin
      act_data  = {2'd1, 9'(i + 1), 32'hA000_0000 + 32'(i)};
      act_valid = 1'b1;
      tick();
      chk("b2b_wr", {22'd0, wr_valid, wr_chan, wr_data}, {22'd0, 1'b1, 9'(i + 1), 32'hA000_0000 + 32'(i)});
    end
    act_valid = 1'b0;
    tick();
    chk("b2b_wr_end", 64'(wr_valid), 64'd0);

    do_read("rd_min", 16'h0100, 9'h013, 16'h0008, 8'h2A, 32'hCAFEF00D, 0, 0, 0);
    do_read("rd_bp", 16'h0100, 9'h013, 16'h0008, 8'h2A, 32'hCAFEF00D, 0, 5, 5);
    do_read("rd_slow", 16'h0100, 9'h013, 16'h0008, 8'h2A, 32'hCAFEF00D, 10, 0, 0);

    // reset in the middle of SEND_QW0
    cfg_bus_dev = 16'h0100;
    act_data    = {2'd0, 9'h013, 16'h0008, 8'h2A, 8'h00};
    act_valid   = 1'b1;
    tick();
    act_valid = 1'b0;
    rd_ack    = 1'b1; rd_data = 32'h1111_2222;
    tick();
    rd_ack    = 1'b0;
    chk("rst_mid_pre", 64'(tx_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_txv", 64'({tx_valid, tx_sop, tx_eop, rd_req}), 64'd0);
    chk("rst_mid_err", 64'({err_code, err_count}), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("rst_mid_release", 64'({act_ready, tx_valid}), 64'b10);
    rd_ack = 1'b1; rd_data = 32'h5555_5555;
    tick();
    rd_ack = 1'b0;
    chk("late_ack_ignored", 64'({rd_req, tx_valid, tx_eop, act_ready}), 64'b0001);
    tick();
    chk("late_ack_no_tlp", 64'({tx_valid, tx_eop}), 64'd0);
    do_read("rd_after_rst", 16'h0ABC, 9'h1F7, 16'h1234, 8'h5C, 32'h0102_0304, 2, 1, 2);

    // randomized traffic against the transaction model
    m_inflight = 0; m_acked = 0; m_wr_pend = 0; m_code = 0; m_cnt = 0; m_cnt2 = 0;
    m_wr_chan = 0; m_wr_data = 0; m_rd_chan = 0; m_bd = 0; m_rid = 0; m_tag = 0;
    prev_stall = 0; prev_tx = '0;
    for (int cyc = 0; cyc < 3400; cyc++) begin
      logic drain, acc, ackc, beatc;
      drain = (cyc >= 3000);
      if (drain && !m_inflight && !m_wr_pend) break;
      // post-edge observations
      chk("rnd_wr_valid", 64'(wr_valid), 64'(m_wr_pend));
      if (m_wr_pend) chk("rnd_wr_fields", {23'd0, wr_chan, wr_data}, {23'd0, m_wr_chan, m_wr_data});
      m_wr_pend = 1'b0;
      chk("rnd_err_code", 64'(err_code), 64'(m_code));
      chk("rnd_err_count", 64'(err_count), 64'(m_cnt));
      chk("rnd_err_count_w2", 64'(d2_err_count), 64'(m_cnt2));
      chk("rnd_ready", 64'(act_ready), 64'(!m_inflight));
      chk("rnd_req", 64'(rd_req), 64'(m_inflight && !m_acked));
      chk("rnd_txv", 64'(tx_valid), 64'(m_inflight && m_acked));
      if (prev_stall && tx_valid)
        chk("rnd_tx_stable", {tx_data[63:2], 2'b00}, {prev_tx[65:4], 2'b00} | 64'(0));
      // drive next inputs
      act_valid   = drain ? 1'b0 : ($urandom % 2 == 0);
      act_data    = {2'($urandom % 4), 9'($urandom), 32'($urandom)};
      cfg_bus_dev = 16'($urandom);
      tx_ready    = drain ? 1'b1 : ($urandom % 3 != 0);
      rd_ack      = drain ? 1'b1 : ((m_inflight && !m_acked) ? ($urandom % 3 == 0) : ($urandom % 8 == 0));
      rd_data     = $urandom;
      // model consumption at the coming edge
      acc   = act_valid && !m_inflight;
      ackc  = rd_ack && m_inflight && !m_acked;
      beatc = tx_ready && m_inflight && m_acked;
      if (beatc) begin
        if (beats_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL rnd_beat: got unexpected beat %h expected none", tx_data);
        end else begin
          beat_t b;
          b = beats_q.pop_front();
          chk("rnd_beat", {tx_data[63:2], 2'b00} | 64'(0), {b.d[63:2], 2'b00});
          chk("rnd_beat_lo", 64'({tx_data[1:0], tx_sop, tx_eop}), 64'({b.d[1:0], b.sop, b.eop}));
          if (b.eop) begin m_inflight = 1'b0; m_acked = 1'b0; end
        end
      end
      if (ackc) begin
        m_acked = 1'b1;
        beats_q.push_back('{{m_bd, 16'h0004, 32'h4A00_0001}, 1'b1, 1'b0});
        beats_q.push_back('{({32'h0, rd_data} << 32) | (64'(m_rid) << 16) | (64'(m_tag) << 8)
                            | (64'(m_rd_chan % 16) << 3) | 64'd4, 1'b0, 1'b1});
      end
      if (acc) begin
        case (act_data[42:41])
          2'd0: begin
            m_inflight = 1'b1; m_acked = 1'b0; m_rd_chan = act_data[40:32];
            m_bd = cfg_bus_dev; m_rid = act_data[31:16]; m_tag = act_data[15:8];
          end
          2'd1: begin m_wr_pend = 1'b1; m_wr_chan = act_data[40:32]; m_wr_data = act_data[31:0]; end
          2'd2: begin
            m_code = act_data[31:0];
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (m_cnt2 < 3) m_cnt2 = m_cnt2 + 1;
          end
          default: ;
        endcase
      end
      prev_stall = tx_valid && !tx_ready;
      prev_tx    = {tx_data, tx_sop, tx_eop};
      tick();
    end
    act_valid = 1'b0; rd_ack = 1'b0; tx_ready = 1'b0;
    chk("rnd_drained", 64'({m_inflight, m_wr_pend}), 64'd0);
    chk("rnd_beats_left", 64'(beats_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
